// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round controller: default round count,
// FSM state encoding and the GF(2^8) round-constant helpers.
package aes_pkg;

  localparam int ROUND_DEFAULT = 10;
  localparam int ROUND_MAX     = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_e;

  // Multiply by x in GF(2^8), reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for round r (1-based); round 0 means "no expansion" and yields 0.
  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] v;
    v = 8'h01;
    if (r < 1) begin
      return 8'h00;
    end
    for (int i = 1; i < r; i++) begin
      v = xtime(v);
    end
    return v;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the round controller
// (slave side) and the requester/datapath (master side).
interface aes_round_ctrl_if;
  logic       valid;
  logic       Ready;
  logic       busy;
  logic       state_load;
  logic       key_load;
  logic       round_en;
  logic       key_en;
  logic       last_round;
  logic [7:0] rcon;
  logic [3:0] round_cnt;

  modport master (
    output valid,
    input  Ready, busy, state_load, key_load, round_en, key_en,
           last_round, rcon, round_cnt
  );

  modport slave (
    input  valid,
    output Ready, busy, state_load, key_load, round_en, key_en,
           last_round, rcon, round_cnt
  );
endinterface

// File: rtl/aes_rcon_gen.sv
// Combinational round-number to round-constant lookup; rounds outside 1..10 map to 0.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic [3:0] round_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_tab [0:15];

  for (genvar gi = 0; gi < 16; gi++) begin : g_tab
    localparam logic [7:0] RCON_V = (gi <= ROUND_MAX) ? rcon_of(gi) : 8'h00;
    assign rcon_tab[gi] = RCON_V;
  end

  assign rcon_o = rcon_tab[round_i];

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 iterative round controller: sequences LOAD, ROUND rounds and DONE,
// driving datapath/key-schedule strobes decoded from the registered state and counter.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int ROUND = ROUND_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_ctrl_if.slave  bus
);

  if (ROUND < 1 || ROUND > ROUND_MAX) begin : g_bad_round
    $error("aes_round_ctrl: ROUND must lie in 1..10");
  end

  localparam logic [3:0] ROUND_W = 4'(ROUND);

  aes_state_e state_q;
  logic [3:0] cnt_q;
  logic [7:0] rcon;

  // The counter is only non-zero in ROUND, so rcon falls back to 0 elsewhere for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.valid) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_q <= ST_ROUND;
          cnt_q   <= 4'd1;
        end
        ST_ROUND: begin
          if (cnt_q == ROUND_W) begin
            state_q <= ST_DONE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q   <= cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (!bus.valid) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  aes_rcon_gen u_rcon_gen (
    .round_i (cnt_q),
    .rcon_o  (rcon)
  );

  assign bus.Ready      = (state_q == ST_DONE);
  assign bus.busy       = (state_q == ST_LOAD) || (state_q == ST_ROUND);
  assign bus.state_load = (state_q == ST_LOAD);
  assign bus.key_load   = (state_q == ST_LOAD);
  assign bus.round_en   = (state_q == ST_ROUND);
  assign bus.key_en     = (state_q == ST_ROUND);
  assign bus.last_round = (state_q == ST_ROUND) && (cnt_q == ROUND_W);
  assign bus.rcon       = rcon;
  assign bus.round_cnt  = cnt_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: a ROUND=10 and a ROUND=1 instance run side by side,
// checked every cycle against a transaction-age reference model.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_round_ctrl_if if_a ();
  aes_round_ctrl_if if_b ();

  aes_round_ctrl #(.ROUND(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  aes_round_ctrl #(.ROUND(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  logic [31:0] obs [2];
  assign obs[0] = {12'd0, if_a.Ready, if_a.busy, if_a.state_load, if_a.key_load, if_a.round_en,
                   if_a.key_en, if_a.last_round, if_a.rcon, if_a.round_cnt};
  assign obs[1] = {12'd0, if_b.Ready, if_b.busy, if_b.state_load, if_b.key_load, if_b.round_en,
                   if_b.key_en, if_b.last_round, if_b.rcon, if_b.round_cnt};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: age = edges since the accepting edge (-1 when no request is active).
  // age 0 is the load cycle, 1..R are rounds, R+1 is the result-held phase.
  int rounds [2] = '{10, 1};
  int age [2];
  int acc_cyc [2];
  bit prev_rdy [2];
  logic [7:0] rcon_ref [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] expect_vec(input int a, input int r);
    bit         load;
    bit         rnd;
    bit         rdy;
    logic [3:0] cnt;
    logic [7:0] rc;
    load = (a == 0);
    rnd  = (a >= 1) && (a <= r);
    rdy  = (a == r + 1);
    cnt  = rnd ? 4'(a) : 4'd0;
    rc   = rnd ? rcon_ref[a] : 8'h00;
    return {12'd0, rdy, load | rnd, load, load, rnd, rnd, rnd && (a == r), rc, cnt};
  endfunction

  function automatic void model_step(input int k, input bit v);
    if (age[k] < 0) begin
      if (v) begin
        age[k]     = 0;
        acc_cyc[k] = cyc;
      end
    end else if (age[k] <= rounds[k]) begin
      age[k] = age[k] + 1;
    end else if (!v) begin
      age[k] = -1;
    end
  endfunction

  task automatic check_all();
    bit rdy;
    for (int k = 0; k < 2; k++) begin
      check_val(k == 0 ? "out_r10" : "out_r1", obs[k], expect_vec(age[k], rounds[k]));
      rdy = obs[k][19];
      if (rdy && !prev_rdy[k]) begin
        check_val(k == 0 ? "lat_r10" : "lat_r1", 32'(cyc - acc_cyc[k]), 32'(rounds[k] + 1));
      end
      prev_rdy[k] = rdy;
    end
  endtask

  // Drive valid, let one rising edge happen, check at the following falling edge.
  task automatic cycle(input bit va, input bit vb);
    if_a.valid = va;
    if_b.valid = vb;
    @(posedge clk);
    cyc++;
    model_step(0, va);
    model_step(1, vb);
    @(negedge clk);
    check_all();
  endtask

  // Pulse reset between edges; outputs must clear before any clock edge arrives.
  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val("rst_clear", obs[k], 32'd0);
      age[k]      = -1;
      prev_rdy[k] = 1'b0;
    end
    #1 rst_n = 1'b1;
  endtask

  bit va_r;
  bit vb_r;

  initial begin
    rst_n      = 1'b0;
    if_a.valid = 1'b0;
    if_b.valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      age[k]      = -1;
      acc_cyc[k]  = 0;
      prev_rdy[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_a", obs[0], 32'd0);
    check_val("reset_b", obs[1], 32'd0);
    rst_n = 1'b1;

    // Nominal request held through Ready, then 5 extra held cycles.
    repeat (12) cycle(1'b1, 1'b1);
    repeat (5)  cycle(1'b1, 1'b1);
    // One low edge then re-raise: a fresh request with identical latency.
    cycle(1'b0, 1'b0);
    repeat (12) cycle(1'b1, 1'b1);
    repeat (3)  cycle(1'b0, 1'b0);

    // Abort attempt: valid drops while round_cnt==4; the operation still completes.
    repeat (4)  cycle(1'b1, 1'b1);
    repeat (12) cycle(1'b0, 1'b0);

    // Reset mid-operation at round_cnt==5 with valid still high; restart at first edge.
    repeat (6) cycle(1'b1, 1'b1);
    async_reset();
    repeat (13) cycle(1'b1, 1'b1);
    repeat (2)  cycle(1'b0, 1'b0);

    // Randomized requester behaviour with sticky valid and occasional resets.
    va_r = 1'b0;
    vb_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) va_r = ~va_r;
      if ($urandom_range(0, 5) == 0) vb_r = ~vb_r;
      cycle(va_r, vb_r);
      if ($urandom_range(0, 249) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
